// File: rtl/fetch_unit.sv
// PC and fetch control feeding a 32-word synchronous-read instruction memory; the fetch latency is one cycle.
// Stall holds all state, and redirect flushes the in-flight word. Defining FETCH_COUNT_EN adds a saturating accepted-instruction count.
module fetch_unit #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instruction,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_valid_q, pend_valid_d;

  // On a stall, re-read the pending word so that the registered memory output stays stable.
  assign imem_addr   = stall ? pend_pc_q : pc_q;
  assign instr_valid = pend_valid_q;
  assign instr_pc    = pend_pc_q;
  assign instr_out   = pend_valid_q ? imem_instruction : NOP_WORD;

  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    if (redirect) begin
      pc_d         = redirect_pc;
      pend_valid_d = 1'b0;
    end else if (!stall) begin
      pend_pc_d    = pc_q;
      pend_valid_d = 1'b1;
      pc_d         = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pend_valid_q && !stall && !redirect && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: it runs directed vector rows with fixed expectations, then random traffic against a reference model of the fetch rules.
module tb_fetch_unit;
  localparam int          AW  = 5;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [31:0]   imem_instruction, instr_out;
  logic          instr_valid;
`ifdef FETCH_COUNT_EN
  logic [15:0]   fetch_count;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_instruction(imem_instruction), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  logic [31:0] mem [32];
  always @(posedge clk) imem_instruction <= mem[imem_addr];

  // Reference view: the address shown to decode, the next address to fetch, and the accepted count.
  int m_show, m_next, m_cnt;
  bit m_valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          rst, st, rd;
    logic [4:0]  rpc;
    bit          ca;     // check imem_addr before the edge
    logic [4:0]  addr;
    bit          v;
    logic [4:0]  pc;
    logic [31:0] ins;
  } vec_t;
  vec_t tv [$];

  function automatic vec_t mk(bit rst, bit st, bit rd, int rpc, bit ca, int addr,
                              bit v, int pc, logic [31:0] ins);
    vec_t x;
    x.rst = rst; x.st = st; x.rd = rd; x.rpc = 5'(rpc); x.ca = ca;
    x.addr = 5'(addr); x.v = v; x.pc = 5'(pc); x.ins = ins;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit d, input int t);
    if (r) begin
      m_show = 0; m_next = 0; m_valid = 0; m_cnt = 0;
    end else begin
      if (m_valid && !s && !d && m_cnt < 65535) m_cnt++;
      if (d) begin
        m_next = t; m_valid = 0;
      end else if (!s) begin
        m_show = m_next; m_valid = 1; m_next = (m_next + 1) % 32;
      end
    end
  endtask

  task automatic check_count();
`ifdef FETCH_COUNT_EN
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h2001_0003;
    mem[1] = 32'h2002_0003;
    mem[2] = 32'h0022_1818;
    m_show = 0; m_next = 0; m_valid = 0; m_cnt = 0;

    //         rst st rd rpc ca addr  v  pc ins
    tv.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0, NOP));
    tv.push_back(mk(1, 0, 0,  0, 1,  0, 0,  0, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1,  0, 1,  0, 32'h2001_0003));
    tv.push_back(mk(0, 0, 0,  0, 1,  1, 1,  1, 32'h2002_0003));
    tv.push_back(mk(0, 1, 0,  0, 1,  1, 1,  1, 32'h2002_0003));
    tv.push_back(mk(0, 1, 0,  0, 1,  1, 1,  1, 32'h2002_0003));
    tv.push_back(mk(0, 1, 0,  0, 1,  1, 1,  1, 32'h2002_0003));
    tv.push_back(mk(0, 0, 0,  0, 1,  2, 1,  2, 32'h0022_1818));
    tv.push_back(mk(0, 0, 0,  0, 1,  3, 1,  3, 32'h1000_0003));
    tv.push_back(mk(0, 0, 1, 20, 1,  4, 0,  3, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1, 20, 1, 20, 32'h1000_0014));
    tv.push_back(mk(0, 1, 1,  7, 1, 20, 0, 20, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1,  7, 1,  7, 32'h1000_0007));
    tv.push_back(mk(0, 0, 1, 30, 1,  8, 0,  7, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1, 30, 1, 30, 32'h1000_001E));
    tv.push_back(mk(0, 0, 0,  0, 1, 31, 1, 31, 32'h1000_001F));
    tv.push_back(mk(0, 0, 0,  0, 1,  0, 1,  0, 32'h2001_0003));
    tv.push_back(mk(0, 0, 0,  0, 1,  1, 1,  1, 32'h2002_0003));
    tv.push_back(mk(0, 0, 1, 12, 1,  2, 0,  1, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1, 12, 1, 12, 32'h1000_000C));
    tv.push_back(mk(1, 1, 0,  0, 1, 12, 0,  0, NOP));
    tv.push_back(mk(0, 1, 0,  0, 1,  0, 0,  0, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1,  0, 1,  0, 32'h2001_0003));
    tv.push_back(mk(0, 0, 0,  0, 1,  1, 1,  1, 32'h2002_0003));
    tv.push_back(mk(0, 0, 1,  2, 1,  2, 0,  1, NOP));
    tv.push_back(mk(0, 0, 0,  0, 1,  2, 1,  2, 32'h0022_1818));

    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; stall = tv[i].st; redirect = tv[i].rd; redirect_pc = tv[i].rpc;
      #1;
      if (tv[i].ca) chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tv[i].addr));
      @(posedge clk);
      model_edge(tv[i].rst, tv[i].st, tv[i].rd, int'(tv[i].rpc));
      @(negedge clk);
      chk($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tv[i].v));
      chk($sformatf("row%0d instr_pc", i), 32'(instr_pc), 32'(tv[i].pc));
      chk($sformatf("row%0d instr_out", i), instr_out, tv[i].ins);
      check_count();
    end

    for (int i = 0; i < 400; i++) begin
      bit r, s, d;
      int t;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0);
      t = int'($urandom_range(0, 31));
      reset = r; stall = s; redirect = d; redirect_pc = 5'(t);
      #1;
      chk("rand imem_addr", 32'(imem_addr), 32'(s ? m_show : m_next));
      @(posedge clk);
      model_edge(r, s, d, t);
      @(negedge clk);
      chk("rand instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("rand instr_pc", 32'(instr_pc), 32'(m_show));
      chk("rand instr_out", instr_out, m_valid ? mem[m_show] : NOP);
      check_count();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
